// File: rtl/knn_sp_pkg.sv
// Shared types and constants for the partialKnn local search-point (SP)
// buffer read streamer.
package knn_sp_pkg;

    // Geometry of the local SP URAM buffer (256-bit x 2048, single port).
    localparam int SP_DATA_W = 256;
    localparam int SP_ADDR_W = 11;
    localparam int SP_DEPTH  = 2048;

    // Word counters must hold 0..SP_DEPTH inclusive, hence one extra bit.
    localparam int SP_CNT_W  = SP_ADDR_W + 1;

    // Streamer control states.
    //   IDLE   : waiting for a start command
    //   STREAM : still issuing buffer reads
    //   DRAIN  : every read issued, waiting for the last word to leave
    //   DONE   : single-cycle completion pulse
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } sp_state_e;

endpackage

// File: rtl/knn_sp_out_fifo.sv
// Output FIFO of the SP streamer. Entry 0 is always the head and is a plain
// register, so head_o/valid_o leave the block straight from flops. Entries at
// or above the fill level are kept at zero, which makes the head read as all
// zeros (data and last flag) whenever the FIFO is empty.
module knn_sp_out_fifo #(
    parameter int Width = 257,
    parameter int Depth = 3,
    parameter int CntW  = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             valid_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             valid_q;

    // Next storage contents: shift down on pop, then write at the fill level.
    always_comb begin
        // NOTE: every signal gets a default before any condition, otherwise the
        // paths that do not assign it would infer a latch.
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (pop_i) begin
            for (int i = 0; i < Depth - 1; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
            mem_d[Depth-1] = '0;
            cnt_d          = cnt_q - CntW'(1);
        end
        if (push_i) begin
            for (int i = 0; i < Depth; i++) begin
                if (cnt_d == CntW'(i)) begin
                    mem_d[i] = push_data_i;
                end
            end
            cnt_d = cnt_d + CntW'(1);
        end
    end

    // Storage, fill level and registered valid flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the storage is reset too: entry 0 drives the output port
            // directly and the zero-above-fill-level invariant needs a clean start.
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= mem_d[i];
            end
            cnt_q   <= cnt_d;
            valid_q <= (cnt_d != '0);
        end
    end

    assign head_o  = mem_q[0];
    assign valid_o = valid_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/knn_local_sp_streamer.sv
// Read-side streamer for the partialKnn local SP buffer. A start command
// launches sequential reads (address wraps from the top of the buffer back to
// 0); the returning words go through a small output FIFO onto a valid/ready
// stream with a last flag. Reads are only issued while the words already in
// flight plus those waiting in the FIFO leave room, so backpressure can never
// overflow the FIFO.
//
// Build option: define KNN_SP_STREAM_PERF_EN to add the 32-bit stall_cycles_o
// port, a saturating count of cycles with out_valid_o && !out_ready_i.
module knn_local_sp_streamer
    import knn_sp_pkg::*;
#(
    parameter int DataWidth    = SP_DATA_W,
    parameter int AddressWidth = SP_ADDR_W,
    parameter int AddressRange = SP_DEPTH,
    parameter int ReadLatency  = 1,
    parameter int FifoDepth    = ReadLatency + 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic [AddressWidth-1:0] base_addr_i,
    input  logic [AddressWidth:0]   num_words_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [AddressWidth-1:0] mem_address0_o,
    output logic                    mem_ce0_o,
    output logic                    mem_we0_o,
    input  logic [DataWidth-1:0]    mem_q0_i,
    output logic [DataWidth-1:0]    out_data_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    out_last_o
`ifdef KNN_SP_STREAM_PERF_EN
    ,
    output logic [31:0]             stall_cycles_o
`endif
);

    localparam int CntW     = AddressWidth + 1;
    localparam int FifoW    = DataWidth + 1;
    localparam int FifoCntW = $clog2(FifoDepth + 1);
    localparam int OccW     = $clog2(FifoDepth + ReadLatency + 2) + 1;

    // Control state and latched command.
    sp_state_e              state_q, state_d;
    logic [CntW-1:0]         num_q, num_d;
    logic [CntW-1:0]         issued_q, issued_d;
    logic [AddressWidth-1:0] rd_addr_q, rd_addr_d;

    // Registered buffer port and per-read last tag.
    logic [AddressWidth-1:0] mem_addr_q, mem_addr_d;
    logic                    ce_q, ce_d;
    logic                    ce_last_q, ce_last_d;
    logic                    busy_q, done_q;

    // In-flight tracking: valid and last bits travel with each read.
    logic [ReadLatency-1:0]  pipe_v_q, pipe_l_q;

    // Issue decision helpers.
    logic                    issue_ok;
    logic [CntW-1:0]         issue_cnt, issue_num;
    logic [AddressWidth-1:0] issue_addr;
    logic [OccW-1:0]         occ_now, occ_next;

    // FIFO interface.
    logic                    fifo_push, fifo_pop, fifo_valid;
    logic [FifoW-1:0]        fifo_head;
    logic [FifoCntW-1:0]     fifo_count;

    assign fifo_push = pipe_v_q[ReadLatency-1];
    assign fifo_pop  = fifo_valid && out_ready_i;

    // Words already committed to the FIFO: the read on the port this cycle,
    // the reads still in the latency pipe and the FIFO contents. Subtracting
    // this cycle's pop gives the occupancy seen by a read issued next cycle.
    always_comb begin
        occ_now = OccW'(ce_q) + OccW'(fifo_count);
        for (int i = 0; i < ReadLatency; i++) begin
            occ_now = occ_now + OccW'(pipe_v_q[i]);
        end
        occ_next = occ_now - OccW'(fifo_pop);
    end

    // Next-state logic: command acceptance, read issue and completion.
    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        issued_d   = issued_q;
        rd_addr_d  = rd_addr_q;
        mem_addr_d = mem_addr_q;
        ce_d       = 1'b0;
        ce_last_d  = 1'b0;
        issue_ok   = 1'b0;
        issue_cnt  = issued_q;
        issue_num  = num_q;
        issue_addr = rd_addr_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    // Work from the live inputs this cycle; the latched copies
                    // take over from the next cycle on.
                    num_d      = num_words_i;
                    issued_d   = '0;
                    rd_addr_d  = base_addr_i;
                    issue_cnt  = '0;
                    issue_num  = num_words_i;
                    issue_addr = base_addr_i;
                    if (num_words_i == '0) begin
                        state_d = DONE;
                    end else begin
                        // Nothing is in flight in IDLE, so the first read
                        // always has room.
                        state_d  = STREAM;
                        issue_ok = 1'b1;
                    end
                end
            end
            STREAM: begin
                issue_ok = (issued_q < num_q) && (occ_next < OccW'(FifoDepth));
            end
            DRAIN: begin
                if (fifo_pop && out_last_o) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue_ok) begin
            ce_d       = 1'b1;
            mem_addr_d = issue_addr;
            issued_d   = issue_cnt + CntW'(1);
            ce_last_d  = ((issue_cnt + CntW'(1)) == issue_num);
            rd_addr_d  = (issue_addr == AddressWidth'(AddressRange - 1))
                       ? '0 : issue_addr + AddressWidth'(1);
            if (ce_last_d) begin
                state_d = DRAIN;
            end
        end
    end

    // FSM state, counters, registered outputs and the in-flight pipe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            num_q      <= '0;
            issued_q   <= '0;
            rd_addr_q  <= '0;
            mem_addr_q <= '0;
            ce_q       <= 1'b0;
            ce_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pipe_v_q   <= '0;
            pipe_l_q   <= '0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            issued_q   <= issued_d;
            rd_addr_q  <= rd_addr_d;
            mem_addr_q <= mem_addr_d;
            ce_q       <= ce_d;
            ce_last_q  <= ce_last_d;
            busy_q     <= (state_d == STREAM) || (state_d == DRAIN);
            done_q     <= (state_d == DONE);
            pipe_v_q[0] <= ce_q;
            pipe_l_q[0] <= ce_last_q;
            for (int i = 1; i < ReadLatency; i++) begin
                pipe_v_q[i] <= pipe_v_q[i-1];
                pipe_l_q[i] <= pipe_l_q[i-1];
            end
        end
    end

    knn_sp_out_fifo #(
        .Width (FifoW),
        .Depth (FifoDepth),
        .CntW  (FifoCntW)
    ) u_out_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i ({pipe_l_q[ReadLatency-1], mem_q0_i}),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .valid_o     (fifo_valid),
        .count_o     (fifo_count)
    );

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign mem_address0_o = mem_addr_q;
    assign mem_ce0_o      = ce_q;
    assign mem_we0_o      = 1'b0;
    assign out_data_o     = fifo_head[DataWidth-1:0];
    assign out_last_o     = fifo_head[DataWidth];
    assign out_valid_o    = fifo_valid;

`ifdef KNN_SP_STREAM_PERF_EN
    logic [31:0] stall_q;

    // Saturating backpressure counter, restarted by each accepted command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (state_q == IDLE && start_i) begin
            stall_q <= '0;
        end else if (fifo_valid && !out_ready_i && stall_q != '1) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_knn_local_sp_streamer.sv
// Directed bench for knn_local_sp_streamer. Two instances share the clock and
// reset: one with ReadLatency=1 and one with ReadLatency=4, each backed by a
// behavioural SP buffer model. Honours KNN_SP_STREAM_PERF_EN when defined.
module tb_knn_local_sp_streamer;

    logic clk;
    logic reset;

    // Shared stimulus; start is steered to one instance by sel4.
    logic        sel4;
    logic        start;
    logic [10:0] base_addr;
    logic [11:0] num_words;
    logic        out_ready;
    logic        start1, start4;

    // Instance with ReadLatency=1.
    logic         busy1, done1, ce1, we1, valid1, last1;
    logic [10:0]  addr1;
    logic [255:0] q1, data1;
    // Instance with ReadLatency=4.
    logic         busy4, done4, ce4, we4, valid4, last4;
    logic [10:0]  addr4;
    logic [255:0] q4, data4;
`ifdef KNN_SP_STREAM_PERF_EN
    logic [31:0]  stall1, stall4;
`endif

    assign start1 = start & ~sel4;
    assign start4 = start & sel4;

    knn_local_sp_streamer #(.ReadLatency(1)) u_dut1 (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start1),
        .base_addr_i    (base_addr),
        .num_words_i    (num_words),
        .busy_o         (busy1),
        .done_o         (done1),
        .mem_address0_o (addr1),
        .mem_ce0_o      (ce1),
        .mem_we0_o      (we1),
        .mem_q0_i       (q1),
        .out_data_o     (data1),
        .out_valid_o    (valid1),
        .out_ready_i    (out_ready),
        .out_last_o     (last1)
`ifdef KNN_SP_STREAM_PERF_EN
        ,
        .stall_cycles_o (stall1)
`endif
    );

    knn_local_sp_streamer #(.ReadLatency(4)) u_dut4 (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start4),
        .base_addr_i    (base_addr),
        .num_words_i    (num_words),
        .busy_o         (busy4),
        .done_o         (done4),
        .mem_address0_o (addr4),
        .mem_ce0_o      (ce4),
        .mem_we0_o      (we4),
        .mem_q0_i       (q4),
        .out_data_o     (data4),
        .out_valid_o    (valid4),
        .out_ready_i    (out_ready),
        .out_last_o     (last4)
`ifdef KNN_SP_STREAM_PERF_EN
        ,
        .stall_cycles_o (stall4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer contents: each 32-bit lane tags the address.
    function automatic logic [255:0] word_of(input logic [10:0] a);
        return {8{~a[7:0], 13'h0AB5, a}};
    endfunction

    localparam logic [255:0] POISON = {8{32'hDEAD_BEEF}};

    // Buffer models: data appears ReadLatency cycles after the read; cycles
    // without a read return poison so stale captures are visible.
    logic [255:0] mq1;
    logic [255:0] mq4 [4];
    always @(posedge clk) begin
        mq1    <= ce1 ? word_of(addr1) : POISON;
        mq4[0] <= ce4 ? word_of(addr4) : POISON;
        for (int i = 1; i < 4; i++) mq4[i] <= mq4[i-1];
    end
    assign q1 = mq1;
    assign q4 = mq4[3];

    // Monitored view of the selected instance.
    logic         m_ce, m_valid, m_last, m_done, m_busy;
    logic [10:0]  m_addr;
    logic [255:0] m_data;
    assign m_ce    = sel4 ? ce4    : ce1;
    assign m_valid = sel4 ? valid4 : valid1;
    assign m_last  = sel4 ? last4  : last1;
    assign m_done  = sel4 ? done4  : done1;
    assign m_busy  = sel4 ? busy4  : busy1;
    assign m_addr  = sel4 ? addr4  : addr1;
    assign m_data  = sel4 ? data4  : data1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-run observations.
    logic [10:0]  ce_addrs [$];
    int           ce_cycs  [$];
    logic [255:0] hs_words [$];
    bit           hs_lasts [$];
    int           hs_cycs  [$];
    int done_cyc, done_cnt, valid_cnt, stall_exp, max_occ, stable_bad;
    logic busy_c1;

    // One command: start at cycle 0, then watch until two cycles past done.
    task automatic run_case(input bit use4, input logic [10:0] base, input logic [11:0] num,
                            input bit stall_mode, input int restart_cyc, input int max_cyc);
        int cyc, issued, accepted, occ;
        bit fin, prev_stall, prev_last;
        logic [255:0] prev_data;
        ce_addrs.delete(); ce_cycs.delete();
        hs_words.delete(); hs_lasts.delete(); hs_cycs.delete();
        done_cyc = -1; done_cnt = 0; valid_cnt = 0; stall_exp = 0;
        max_occ = 0; stable_bad = 0; busy_c1 = 1'b0;
        issued = 0; accepted = 0; prev_stall = 0; prev_last = 0; prev_data = '0;
        sel4 = use4;
        @(negedge clk);
        start = 1'b1; base_addr = base; num_words = num; out_ready = 1'b1;
        cyc = 0; fin = 0;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            start     = (cyc == restart_cyc);
            base_addr = 11'h3AA;
            num_words = 12'd7;
            out_ready = stall_mode ? (cyc % 3 == 0) : 1'b1;
            if (m_ce) begin
                ce_addrs.push_back(m_addr);
                ce_cycs.push_back(cyc);
                issued++;
            end
            occ = issued - accepted;
            if (occ > max_occ) max_occ = occ;
            if (prev_stall && (m_data !== prev_data || m_last !== prev_last || !m_valid)) stable_bad++;
            if (m_valid) valid_cnt++;
            if (m_valid && out_ready) begin
                hs_words.push_back(m_data);
                hs_lasts.push_back(m_last);
                hs_cycs.push_back(cyc);
                accepted++;
            end
            if (m_valid && !out_ready) stall_exp++;
            prev_stall = m_valid && !out_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (m_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc == 1) busy_c1 = m_busy;
            if (done_cyc >= 0 && cyc >= done_cyc + 2) fin = 1;
            if (cyc >= max_cyc) fin = 1;
        end
    endtask

    // Words and last flags against the buffer image read from base upwards.
    function automatic int count_bad_words(input logic [10:0] base, input int num);
        int bad;
        logic [10:0] a;
        bad = 0;
        for (int i = 0; i < hs_words.size(); i++) begin
            a = base + 11'(i);
            if (hs_words[i] !== word_of(a)) bad++;
            if (hs_lasts[i] != (i == num - 1)) bad++;
        end
        return bad;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] exp_a [4];
        reset = 1'b0; sel4 = 1'b0; start = 1'b0;
        base_addr = '0; num_words = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Reset state.
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_ce", ce1, 0);
        check("rst_we", we1, 0);
        check("rst_valid", valid1, 0);
        check("rst_last", last1, 0);
        check("rst_addr", addr1, 0);
        check("rst_valid4", valid4, 0);

        // Four words from 0, full throughput, ReadLatency=1.
        run_case(0, 11'd0, 12'd4, 0, -1, 60);
        exp_a = '{11'd0, 11'd1, 11'd2, 11'd3};
        check("t1_ce_count", ce_addrs.size(), 4);
        for (int i = 0; i < ce_addrs.size() && i < 4; i++) begin
            check($sformatf("t1_addr%0d", i), ce_addrs[i], exp_a[i]);
            check($sformatf("t1_ce_cyc%0d", i), ce_cycs[i], i + 1);
        end
        check("t1_first_valid", (hs_cycs.size() > 0) ? hs_cycs[0] : -1, 3);
        check("t1_words", hs_words.size(), 4);
        check("t1_data", count_bad_words(11'd0, 4), 0);
        check("t1_done_cyc", done_cyc, 7);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_busy_c1", busy_c1, 1);
        check("t1_occ_le3", max_occ > 3, 0);
`ifdef KNN_SP_STREAM_PERF_EN
        check("t1_stall", stall1, stall_exp);
`endif

        // Address wrap at the top of the buffer.
        run_case(0, 11'd2046, 12'd4, 0, -1, 60);
        exp_a = '{11'd2046, 11'd2047, 11'd0, 11'd1};
        check("t2_ce_count", ce_addrs.size(), 4);
        for (int i = 0; i < ce_addrs.size() && i < 4; i++) begin
            check($sformatf("t2_addr%0d", i), ce_addrs[i], exp_a[i]);
        end
        check("t2_words", hs_words.size(), 4);
        check("t2_data", count_bad_words(11'd2046, 4), 0);
        check("t2_done_cyc", done_cyc, 7);

        // Zero-length command.
        run_case(0, 11'd17, 12'd0, 0, -1, 30);
        check("t3_ce_count", ce_addrs.size(), 0);
        check("t3_valid_cnt", valid_cnt, 0);
        check("t3_done_cyc", done_cyc, 1);
        check("t3_done_cnt", done_cnt, 1);
        check("t3_busy_c1", busy_c1, 0);

        // Start while busy must be ignored.
        run_case(0, 11'd10, 12'd5, 0, 2, 60);
        check("t6_ce_count", ce_addrs.size(), 5);
        check("t6_words", hs_words.size(), 5);
        check("t6_data", count_bad_words(11'd10, 5), 0);
        check("t6_done_cyc", done_cyc, 8);
        check("t6_done_cnt", done_cnt, 1);

        // ReadLatency=4 latency and completion timing.
        run_case(1, 11'd40, 12'd3, 0, -1, 60);
        check("t4_first_valid", (hs_cycs.size() > 0) ? hs_cycs[0] : -1, 6);
        check("t4_words", hs_words.size(), 3);
        check("t4_data", count_bad_words(11'd40, 3), 0);
        check("t4_done_cyc", done_cyc, 9);

        // Full buffer with heavy backpressure, ReadLatency=4.
        run_case(1, 11'd5, 12'd2048, 1, -1, 8000);
        check("t5_words", hs_words.size(), 2048);
        check("t5_data", count_bad_words(11'd5, 2048), 0);
        check("t5_ce_count", ce_addrs.size(), 2048);
        check("t5_occ_le6", max_occ > 6, 0);
        check("t5_hold_stable", stable_bad, 0);
        check("t5_done_cnt", done_cnt, 1);
`ifdef KNN_SP_STREAM_PERF_EN
        check("t5_stall", stall4, stall_exp);
`endif

        // Reset in the middle of a stream, then a fresh short command.
        sel4 = 1'b0;
        @(negedge clk);
        start = 1'b1; base_addr = 11'd500; num_words = 12'd20; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("t7_pre_busy", busy1, 1);
        reset = 1'b0;
        #1;
        check("t7_rst_busy", busy1, 0);
        check("t7_rst_ce", ce1, 0);
        check("t7_rst_valid", valid1, 0);
        check("t7_rst_last", last1, 0);
        check("t7_rst_addr", addr1, 0);
        check("t7_rst_data", data1, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_case(0, 11'd100, 12'd2, 0, -1, 40);
        check("t7_ce_count", ce_addrs.size(), 2);
        check("t7_words", hs_words.size(), 2);
        check("t7_data", count_bad_words(11'd100, 2), 0);
        check("t7_done_cyc", done_cyc, 5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
